// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares one memory port
//            between two requesters. It also decodes the IO half of the
//            address space: LED output register and switch input sampling.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] io_in,
  output logic [DATA_WIDTH-1:0] io_out,
  output logic                  busy
);

  localparam int            c_CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_CNT_W-1:0] c_BURST_TOP = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_sel;
  logic                  r_last;
  logic [c_CNT_W-1:0]    r_burst;
  logic [DATA_WIDTH-1:0] r_io_out;
  logic [DATA_WIDTH-1:0] r_io_rd_q;
  logic                  r_rd_io;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;

  logic                  w_req_sel;
  logic                  w_we_sel;
  logic                  w_lock_sel;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic [DATA_WIDTH-1:0] w_wdata_sel;
  logic                  w_is_io;
  logic                  w_any_req;
  logic                  w_lock_win;
  logic                  w_win;
  logic                  w_issue;
  logic                  w_rdwait;

  assign w_req_sel   = r_sel ? req1   : req0;
  assign w_we_sel    = r_sel ? we1    : we0;
  assign w_lock_sel  = r_sel ? lock1  : lock0;
  assign w_addr_sel  = r_sel ? addr1  : addr0;
  assign w_wdata_sel = r_sel ? wdata1 : wdata0;
  assign w_is_io     = w_addr_sel[ADDR_WIDTH-1];
  assign w_any_req   = req0 | req1;
  assign w_issue     = (r_state == S_ISSUE);
  assign w_rdwait    = (r_state == S_RDWAIT);

  // A lock only extends an ownership that is live, so a burst starting
  // from IDLE always begins with an ordinary arbitration win.
  assign w_lock_win = (r_state != S_IDLE) && w_req_sel && w_lock_sel &&
                      (r_burst < c_BURST_TOP);

  always_comb begin
    w_win = 1'b0;
    if (w_lock_win) begin
      w_win = r_sel;
    end else if (req0 && req1) begin
      w_win = ~r_last;
    end else begin
      w_win = req1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_burst      <= '0;
      r_io_out     <= '0;
      r_io_rd_q    <= '0;
      r_rd_io      <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      if (w_issue) begin
        r_addr_hold  <= w_addr_sel;
        r_wdata_hold <= w_wdata_sel;
        r_rd_io      <= w_is_io;
        if (w_is_io && w_we_sel) begin
          r_io_out <= w_wdata_sel;
        end
        if (w_is_io && !w_we_sel) begin
          r_io_rd_q <= io_in;
        end
      end

      if (w_issue && !w_we_sel) begin
        r_state <= S_RDWAIT;
      end else if (w_any_req) begin
        r_state <= S_ISSUE;
        r_sel   <= w_win;
        r_last  <= w_win;
        r_burst <= w_lock_win ? (r_burst + c_CNT_ONE) : '0;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign gnt0      = w_issue && !r_sel;
  assign gnt1      = w_issue &&  r_sel;
  assign rvalid0   = w_rdwait && !r_sel;
  assign rvalid1   = w_rdwait &&  r_sel;
  assign mem_addr  = w_issue ? w_addr_sel  : r_addr_hold;
  assign mem_wdata = w_issue ? w_wdata_sel : r_wdata_hold;
  assign mem_we    = w_issue && w_we_sel && !w_is_io;
  assign rdata     = w_rdwait ? (r_rd_io ? r_io_rd_q : mem_rdata) : '0;
  assign io_out    = r_io_out;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
